vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 95 +++++++++
 tb/tb_vga_sync_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, x/y raster counters, blanking and
// active-low syncs, with a one-pixel output register stage toward the connector.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned DIV       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rgb_in,
  output logic        p_tick,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W    = 10;

  logic [DIV_W-1:0] div_cnt;
  logic             hsync_raw;
  logic             vsync_raw;
  logic [11:0]      rgb_blank;

  // Pixel-rate divider: counts 0..DIV-1 and strobes on the last count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign p_tick = (div_cnt == DIV_W'(DIV - 1));

  // Raster counters: x advances per pixel, y advances when a line completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (p_tick) begin
      if (x == CNT_W'(H_TOTAL - 1)) begin
        x <= '0;
        if (y == CNT_W'(V_TOTAL - 1)) begin
          y <= '0;
        end else begin
          y <= y + CNT_W'(1);
        end
      end else begin
        x <= x + CNT_W'(1);
      end
    end
  end

  // Decodes of the registered raster position.
  always_comb begin
    video_on   = (x < CNT_W'(H_DISPLAY)) && (y < CNT_W'(V_DISPLAY));
    frame_tick = p_tick && (x == '0) && (y == CNT_W'(V_DISPLAY + 1));
    hsync_raw  = !((x >= CNT_W'(HS_START)) && (x <= CNT_W'(HS_END)));
    vsync_raw  = !((y >= CNT_W'(VS_START)) && (y <= CNT_W'(VS_END)));
    rgb_blank  = video_on ? rgb_in : 12'h000;
  end

  // Connector stage: syncs and blanked colour captured together once per pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb_out <= 12'h000;
    end else if (p_tick) begin
      hsync   <= hsync_raw;
      vsync   <= vsync_raw;
      rgb_out <= rgb_blank;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster (15x8 pixels, DIV=4) so whole
// frames fit in a short run; expected values come from hand tables and a
// closed-form function of the clock count since reset release.
module tb_vga_sync_gen;

  localparam int HD = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VD = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int DV = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic        clk;
  logic        reset;
  logic [11:0] rgb_in;
  logic        p_tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        frame_tick;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb_out;

  int checks;
  int failures;
  int n;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .DIV(DV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rgb_in(rgb_in),
    .p_tick(p_tick),
    .x(x),
    .y(y),
    .video_on(video_on),
    .frame_tick(frame_tick),
    .hsync(hsync),
    .vsync(vsync),
    .rgb_out(rgb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    logic        pt;
    int          xv;
    int          yv;
    logic        von;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        ft;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (n=%0d)", nm, act, exp, n);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    n++;
    #1;
  endtask

  function automatic logic [11:0] col(input int q);
    return 12'((q * 37 + 5) | 1);
  endfunction

  // Expected outputs after nn edges since release; mode 0: rgb_in=F0F, mode 1: rgb_in=col(pixel).
  function automatic logic [36:0] model(input int nn, input bit mode);
    int p, d, px, py, q, qx, qy;
    logic pt, von, ft, hs, vs;
    logic [11:0] rgb;
    p  = nn / DV;
    d  = nn % DV;
    px = p % HT;
    py = (p / HT) % VT;
    pt = (d == DV - 1);
    von = (px < HD) && (py < VD);
    ft = pt && (px == 0) && (py == VD + 1);
    if (p == 0) begin
      hs = 1'b1; vs = 1'b1; rgb = 12'h000;
    end else begin
      q  = p - 1;
      qx = q % HT;
      qy = (q / HT) % VT;
      hs = !((qx >= HD + HF) && (qx <= HD + HF + HS - 1));
      vs = !((qy >= VD + VF) && (qy <= VD + VF + VS - 1));
      rgb = ((qx < HD) && (qy < VD)) ? (mode ? col(q) : 12'hF0F) : 12'h000;
    end
    return {pt, 10'(px), 10'(py), von, hs, vs, rgb, ft};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ptick"}, 64'(p_tick), 64'(0));
    chk({tag, "_xy"}, 64'({x, y}), 64'(0));
    chk({tag, "_syncs"}, 64'({hsync, vsync}), 64'(2'b11));
    chk({tag, "_rgb"}, 64'(rgb_out), 64'(0));
    chk({tag, "_ftick"}, 64'(frame_tick), 64'(0));
  endtask

  int hs_low, vs_low, ft_cnt;

  initial begin
    checks   = 0;
    failures = 0;
    n        = 0;
    reset    = 1'b1;
    rgb_in   = 12'hF0F;

    //          n    pt  x   y  von hs  vs  rgb      ft
    tbl[0]  = '{0,   0,  0,  0, 1,  1,  1,  12'h000, 0};
    tbl[1]  = '{3,   1,  0,  0, 1,  1,  1,  12'h000, 0};
    tbl[2]  = '{4,   0,  1,  0, 1,  1,  1,  12'hF0F, 0};
    tbl[3]  = '{35,  1,  8,  0, 0,  1,  1,  12'hF0F, 0};
    tbl[4]  = '{36,  0,  9,  0, 0,  1,  1,  12'h000, 0};
    tbl[5]  = '{44,  0,  11, 0, 0,  0,  1,  12'h000, 0};
    tbl[6]  = '{52,  0,  13, 0, 0,  0,  1,  12'h000, 0};
    tbl[7]  = '{56,  0,  14, 0, 0,  1,  1,  12'h000, 0};
    tbl[8]  = '{60,  0,  0,  1, 1,  1,  1,  12'h000, 0};
    tbl[9]  = '{212, 0,  8,  3, 0,  1,  1,  12'hF0F, 0};
    tbl[10] = '{244, 0,  1,  4, 0,  1,  1,  12'h000, 0};
    tbl[11] = '{299, 1,  14, 4, 0,  1,  1,  12'h000, 0};
    tbl[12] = '{303, 1,  0,  5, 0,  1,  1,  12'h000, 1};
    tbl[13] = '{304, 0,  1,  5, 0,  1,  0,  12'h000, 0};
    tbl[14] = '{420, 0,  0,  7, 0,  1,  0,  12'h000, 0};
    tbl[15] = '{424, 0,  1,  7, 0,  1,  1,  12'h000, 0};
    tbl[16] = '{479, 1,  14, 7, 0,  1,  1,  12'h000, 0};
    tbl[17] = '{480, 0,  0,  0, 1,  1,  1,  12'h000, 0};

    // Reset values while held.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset_hold");
    reset = 1'b0;
    n = 0;

    // Directed vectors, constant colour.
    for (int i = 0; i < 18; i++) begin
      while (n < tbl[i].n) step();
      chk($sformatf("vec%0d_ptick", i), 64'(p_tick), 64'(tbl[i].pt));
      chk($sformatf("vec%0d_x", i), 64'(x), 64'(tbl[i].xv));
      chk($sformatf("vec%0d_y", i), 64'(y), 64'(tbl[i].yv));
      chk($sformatf("vec%0d_video_on", i), 64'(video_on), 64'(tbl[i].von));
      chk($sformatf("vec%0d_hsync", i), 64'(hsync), 64'(tbl[i].hs));
      chk($sformatf("vec%0d_vsync", i), 64'(vsync), 64'(tbl[i].vs));
      chk($sformatf("vec%0d_rgb", i), 64'(rgb_out), 64'(tbl[i].rgb));
      chk($sformatf("vec%0d_ftick", i), 64'(frame_tick), 64'(tbl[i].ft));
    end

    // Two full frames against the closed-form model with per-pixel colour.
    do_reset();
    rgb_in = col(0);
    hs_low = 0; vs_low = 0; ft_cnt = 0;
    for (int k = 0; k <= 2 * HT * VT * DV; k++) begin
      if (k > 0) begin
        step();
        rgb_in = col(n / DV);
      end
      chk("scan", 64'({p_tick, x, y, video_on, hsync, vsync, rgb_out, frame_tick}),
          64'(model(n, 1'b1)));
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_tick) ft_cnt++;
    end
    chk("scan_hsync_low_clks", 64'(hs_low), 64'(192));
    chk("scan_vsync_low_clks", 64'(vs_low), 64'(240));
    chk("scan_frame_ticks", 64'(ft_cnt), 64'(2));

    // Mid-frame reset while hsync is active, between clock edges.
    do_reset();
    rgb_in = 12'hF0F;
    while (n < 169) step();
    chk("pre_reset_pos", 64'({x, y}), 64'({10'd12, 10'd2}));
    chk("pre_reset_hsync", 64'(hsync), 64'(0));
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("reset_async");
    rgb_in = 12'hFFF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_reset_vals($sformatf("reset_clk%0d", k));
    end
    reset = 1'b0;
    n = 0;
    step(); step();
    chk("rel_n2_ptick", 64'(p_tick), 64'(0));
    step();
    chk("rel_n3_ptick", 64'(p_tick), 64'(1));
    chk("rel_n3_xy", 64'({x, y}), 64'(0));
    step();
    chk("rel_n4_xy", 64'({x, y}), 64'({10'd1, 10'd0}));
    chk("rel_n4_rgb", 64'(rgb_out), 64'(12'hFFF));
    chk("rel_n4_ptick", 64'(p_tick), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
